// File: rtl/ysyx_25030093_wbu.sv
// ysyx_25030093_wbu: writeback stage with one-entry hold buffer, register/CSR commit and next-PC select.
// Define YSYX_25030093_WBU_INSTRET_EN to enable the 64-bit retired-instruction counter on instret.
module ysyx_25030093_wbu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_rd_wen,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_WIDTH-1:0] in_alu,
    input  logic [DATA_WIDTH-1:0] in_mem,
    input  logic [DATA_WIDTH-1:0] in_csr,
    input  logic                  in_csr_wen,
    input  logic                  in_ecall,
    input  logic                  in_mret,
    input  logic                  in_br_taken,
    input  logic [DATA_WIDTH-1:0] in_csr_wdata,
    input  logic [DATA_WIDTH-1:0] in_br_target,
    input  logic [DATA_WIDTH-1:0] csr_mtvec,
    input  logic [DATA_WIDTH-1:0] csr_mepc,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  csr_wen,
    output logic [DATA_WIDTH-1:0] csr_wdata,
    output logic                  ecall_o,
    output logic [DATA_WIDTH-1:0] ecall_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] next_pc,
    output logic [63:0]           instret
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] pc_r, alu_r, mem_r, csr_r, csr_wdata_r, br_target_r;
    logic [ADDR_WIDTH-1:0] rd_r;
    logic [1:0] wb_sel_r;
    logic rd_wen_r, csr_wen_r, ecall_r, mret_r, br_taken_r;
    logic fire_in, commit;
    logic [DATA_WIDTH-1:0] pc4, wb_data, npc;
    // Reset low also blocks both handshakes so a held result can never commit during reset.
    assign in_ready  = rst & ((state == IDLE) | out_ready);
    assign out_valid = rst & (state == HOLD);
    assign fire_in   = in_valid & in_ready;
    assign commit    = out_valid & out_ready;
    always_comb begin
        state_n = state;
        if (fire_in)
            state_n = HOLD;
        else if (commit)
            state_n = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (fire_in) begin
            pc_r        <= in_pc;
            rd_r        <= in_rd;
            rd_wen_r    <= in_rd_wen;
            wb_sel_r    <= in_wb_sel;
            alu_r       <= in_alu;
            mem_r       <= in_mem;
            csr_r       <= in_csr;
            csr_wen_r   <= in_csr_wen;
            ecall_r     <= in_ecall;
            mret_r      <= in_mret;
            br_taken_r  <= in_br_taken;
            csr_wdata_r <= in_csr_wdata;
            br_target_r <= in_br_target;
        end
    end
    always_comb begin
        pc4     = pc_r + DATA_WIDTH'(4);
        wb_data = wb_sel_r == 2'd0 ? alu_r :
                  wb_sel_r == 2'd1 ? mem_r :
                  wb_sel_r == 2'd2 ? pc4 : csr_r;
        npc     = ecall_r ? csr_mtvec :
                  mret_r ? csr_mepc :
                  br_taken_r ? br_target_r : pc4;
    end
    assign rf_wen    = commit & rd_wen_r & (rd_r != '0);
    assign rf_waddr  = rf_wen ? rd_r : '0;
    assign rf_wdata  = rf_wen ? wb_data : '0;
    assign csr_wen   = commit & csr_wen_r;
    assign csr_wdata = csr_wen ? csr_wdata_r : '0;
    assign ecall_o   = commit & ecall_r;
    assign ecall_pc  = ecall_o ? pc_r : '0;
    always_ff @(posedge clk) begin
        if (!rst)
            next_pc <= RESET_PC;
        else if (commit)
            next_pc <= npc;
    end
`ifdef YSYX_25030093_WBU_INSTRET_EN
    always_ff @(posedge clk) begin
        if (!rst)
            instret <= '0;
        else if (commit)
            instret <= instret + 64'd1;
    end
`else
    assign instret = '0;
`endif
endmodule
